lcd_window_stat: RTL



---
 rtl/lcd_pkg.sv | 8 +
 rtl/lcd_win_acc.sv | 35 +++
 rtl/lcd_window_stat.sv | 94 +++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared widths, window geometry and FSM states for the LCD controller and its consumers
package lcd_pkg;
    localparam int PIX_W      = 8;
    localparam int SUM_W      = 12;
    localparam int WIN_PIX    = 9;
    localparam int CENTER_IDX = 4;
    typedef enum logic {IDLE, COLLECT} state_t;
endpackage

// File: rtl/lcd_win_acc.sv
// lcd_win_acc: running sum/max/min over a pixel burst.
// Ports: clk, reset (sync, active-high); seed restarts the accumulation with pix,
// acc folds pix into the running values; nxt_* give the values including the current pix.
module lcd_win_acc
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             seed,
    input  logic             acc,
    input  logic [PIX_W-1:0] pix,
    output logic [SUM_W-1:0] nxt_sum,
    output logic [PIX_W-1:0] nxt_max,
    output logic [PIX_W-1:0] nxt_min
);
    logic [SUM_W-1:0] sum;
    logic [PIX_W-1:0] max_v, min_v;
    // Ties keep the held value, so only a strict compare replaces it.
    always_comb begin
        nxt_sum = seed ? SUM_W'(pix) : sum + SUM_W'(pix);
        nxt_max = (seed || pix > max_v) ? pix : max_v;
        nxt_min = (seed || pix < min_v) ? pix : min_v;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sum   <= '0;
            max_v <= '0;
            min_v <= '0;
        end else if (seed || acc) begin
            sum   <= nxt_sum;
            max_v <= nxt_max;
            min_v <= nxt_min;
        end
    end
endmodule

// File: rtl/lcd_window_stat.sv
// lcd_window_stat: captures the controller's 3x3 window burst and reports sum/max/min/centre.
// Ports: clk, reset (sync, active-high); pix_in/pix_valid/lcd_busy from the controller;
// win_valid pulse with win_sum/win_max/win_min/win_center/win_count; err_short pulse on an
// aborted burst; rd_addr/rd_data combinational read of the last completed window.
module lcd_window_stat
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             lcd_busy,
    output logic             win_valid,
    output logic [SUM_W-1:0] win_sum,
    output logic [PIX_W-1:0] win_max,
    output logic [PIX_W-1:0] win_min,
    output logic [PIX_W-1:0] win_center,
    output logic [7:0]       win_count,
    output logic             err_short,
    input  logic [3:0]       rd_addr,
    output logic [PIX_W-1:0] rd_data
);
    state_t           state, state_nxt;
    logic [3:0]       idx;
    logic [PIX_W-1:0] work [WIN_PIX];
    logic [PIX_W-1:0] res  [WIN_PIX];
    logic             seed, acc, done, abort;
    logic [SUM_W-1:0] nxt_sum;
    logic [PIX_W-1:0] nxt_max, nxt_min;

    lcd_win_acc u_acc (
        .clk     (clk),
        .reset   (reset),
        .seed    (seed),
        .acc     (acc),
        .pix     (pix_in),
        .nxt_sum (nxt_sum),
        .nxt_max (nxt_max),
        .nxt_min (nxt_min)
    );

    always_comb begin
        seed      = state == IDLE && pix_valid;
        acc       = state == COLLECT && pix_valid;
        done      = acc && idx == 4'(WIN_PIX - 1);
        abort     = state == COLLECT && !pix_valid && !lcd_busy;
        state_nxt = state == IDLE ? (pix_valid ? COLLECT : IDLE)
                                  : ((done || abort) ? IDLE : COLLECT);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            win_valid  <= 1'b0;
            err_short  <= 1'b0;
            win_sum    <= '0;
            win_max    <= '0;
            win_min    <= '0;
            win_center <= '0;
            win_count  <= '0;
            for (int i = 0; i < WIN_PIX; i++) begin
                work[i] <= '0;
                res[i]  <= '0;
            end
        end else begin
            win_valid <= done;
            err_short <= abort;
            // idx is 0 in IDLE, so the first pixel lands in slot 0 through the same path.
            if (pix_valid) begin
                work[idx] <= pix_in;
                idx       <= done ? 4'd0 : idx + 4'd1;
            end else if (abort) begin
                idx <= '0;
            end
            // The ninth pixel is not yet in work, so it is taken straight from pix_in.
            if (done) begin
                win_sum    <= nxt_sum;
                win_max    <= nxt_max;
                win_min    <= nxt_min;
                win_center <= work[CENTER_IDX];
                win_count  <= win_count + 8'd1;
                for (int i = 0; i < WIN_PIX; i++)
                    res[i] <= (i == WIN_PIX - 1) ? pix_in : work[i];
            end
        end
    end

    assign rd_data = (rd_addr < 4'(WIN_PIX)) ? res[rd_addr] : '0;
endmodule
